id_ex_pipe: RTL
===============

# id_ex_pipe

ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and branch flush. It sits between the decode stage and the execute stage. It captures every decoded field plus the register-file read data at each clock edge. When a dependent instruction follows a load, it stalls PC and IF/ID for one cycle. When EX resolves a taken branch, it squashes the wrong-path instruction.

## Interface
Parameters:
- XLEN, 32, datapath width of PC, immediate and register data.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- VALID_ID  in  1  IF/ID holds a real instruction.
- PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID  in  XLEN  decoded values.
- FUNCT3_ID  in  3; FUNCT7_ID  in  7; OPCODE_ID  in  7.
- RD_ID, RS1_ID, RS2_ID  in  5  register indices.
- PCSrc_EX  in  1  taken branch/jump resolved in EX this cycle.
- RegWrite_WB  in  1; RD_WB  in  5; ALU_DATA_WB  in  XLEN  writeback port (bypass only).
- VALID_EX  out  1  EX holds a real instruction.
- PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX  out  XLEN.
- FUNCT3_EX  out  3; FUNCT7_EX  out  7; OPCODE_EX  out  7; RD_EX, RS1_EX, RS2_EX  out  5.
- PCWrite  out  1  PC may advance.
- IF_IDWrite  out  1  IF/ID may load.
- FLUSH_IF_ID  out  1  IF/ID must be invalidated.
- STALL_COUNT, FLUSH_COUNT  out  32  performance counters.

## Operation
- The hazard condition is HZ = VALID_ID & VALID_EX & (OPCODE_EX == LOAD 0000011) & (RD_EX != 0) & ((use_rs1 & RS1_ID == RD_EX) | (use_rs2 & RS2_ID == RD_EX)).
- use_rs1 is 1 unless OPCODE_ID is LUI 0110111, AUIPC 0010111 or JAL 1101111.
- use_rs2 is 1 only for OP 0110011, STORE 0100011 and BRANCH 1100011.
- Per-edge update of the EX register, in priority order:
  - reset: all EX fields are 0, VALID_EX = 0, counters = 0.
  - PCSrc_EX = 1: bubble (all EX fields 0, VALID_EX = 0). FLUSH_COUNT += 1.
  - HZ = 1: bubble. STALL_COUNT += 1.
  - otherwise: capture all *_ID fields and VALID_EX <= VALID_ID.
- Combinational outputs:
  - PCWrite = IF_IDWrite = ~HZ | PCSrc_EX. A flush overrides a stall.
  - FLUSH_IF_ID = PCSrc_EX.
- A stall lasts exactly one cycle. After the bubble, VALID_EX = 0, so HZ clears and the held ID instruction is captured on the next edge.
- Counters are 32-bit and wrap modulo 2^32 with no saturation.
- Bubble encoding is all-zero fields. EX and later stages must treat VALID_EX = 0 as a no-op regardless of the opcode.

## Timing
- ID to EX latency is one cycle; all *_EX outputs are registered.
- PCWrite, IF_IDWrite and FLUSH_IF_ID are combinational from the EX registers and the ID/PCSrc_EX inputs, and are valid in the same cycle.
- Reset values:
  - VALID_EX and all *_EX outputs: 0.
  - Both counters: 0.
  - PCWrite and IF_IDWrite: 1.
  - FLUSH_IF_ID: follows PCSrc_EX.
- Reset asserted mid-stall drops the stall. The instruction held in ID is then re-presented by upstream after reset.
- PCSrc_EX and HZ in the same cycle: flush wins. One bubble is inserted, the flush counter increments and the stall counter does not.

## Configuration
- ID_EX_WB_BYPASS_EN:
  - Defined: on a capture edge, if RegWrite_WB & RD_WB != 0 & RD_WB == RS1_ID, REG_DATA1_EX takes ALU_DATA_WB instead of REG_DATA1_ID. RS2 is handled the same way.
  - This covers a register file that is not write-before-read.
  - Undefined: the read data is captured unmodified.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (LOAD, STORE, OP, OP_IMM, BRANCH, LUI, AUIPC, JAL, JALR);
  - XLEN;
  - the bubble value.
- Sub-module hazard_detect is combinational. It takes OPCODE_ID, RS1_ID, RS2_ID, VALID_ID, VALID_EX, OPCODE_EX and RD_EX, and produces HZ.
- The pipeline register and the counters live in id_ex_pipe.

## Test plan
- Reset held 2 cycles with VALID_ID = 1:
  - During reset, VALID_EX = 0, all EX fields are 0, PCWrite = 1 and counters are 0.
  - On the first edge after release, PC_ID = 0x10 is captured.
- Load then use: EX holds lw x5 (RD_EX = 5) and ID holds add x6,x5,x1:
  - PCWrite = 0 for one cycle.
  - A bubble enters EX and STALL_COUNT = 1.
  - The next edge captures the add.
- Load followed by lui x5 in ID (RD_EX = 5, RS1 field = 5 but unused): no stall.
- Load to x0 followed by an instruction using x0: no stall.
- PCSrc_EX = 1 in the same cycle as HZ = 1:
  - FLUSH_IF_ID = 1 and PCWrite = 1.
  - Bubble in EX; FLUSH_COUNT = 1 and STALL_COUNT is unchanged.
- With ID_EX_WB_BYPASS_EN defined: RegWrite_WB = 1, RD_WB = 3, ALU_DATA_WB = 0xDEADBEEF, RS1_ID = 3 and REG_DATA1_ID = 0 give REG_DATA1_EX = 0xDEADBEEF. Without the macro, REG_DATA1_EX = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 opcode constants, datapath width and bubble encoding
//
// Contents:
//   XLEN             default datapath width
//   OPC_*            7-bit base opcodes used by decode/hazard logic
//   ex_ctrl_t        control/index fields carried in the ID/EX register
//   BUBBLE_CTRL      all-zero control word injected on stall or flush
//   BUBBLE_DATA      all-zero data value injected on stall or flush
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic       valid;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_ctrl_t;

  // A bubble is all-zero; downstream stages key off valid, not the opcode.
  localparam ex_ctrl_t BUBBLE_CTRL = '0;
  localparam logic [XLEN-1:0] BUBBLE_DATA = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detector
//
// Ports:
//   opcode_id  in  7  opcode of the instruction in ID
//   rs1_id     in  5  rs1 field in ID
//   rs2_id     in  5  rs2 field in ID
//   valid_id   in  1  ID holds a real instruction
//   valid_ex   in  1  EX holds a real instruction
//   opcode_ex  in  7  opcode of the instruction in EX
//   rd_ex      in  5  destination of the instruction in EX
//   hz         out 1  ID depends on a load currently in EX
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       valid_id,
  input  logic       valid_ex,
  input  logic [6:0] opcode_ex,
  input  logic [4:0] rd_ex,
  output logic       hz
);

  logic use_rs1;
  logic use_rs2;
  logic load_in_ex;

  // U-type and JAL carry immediate bits where rs1 would be, so they never read rs1.
  assign use_rs1 = !((opcode_id == OPC_LUI) || (opcode_id == OPC_AUIPC) ||
                     (opcode_id == OPC_JAL));
  assign use_rs2 = (opcode_id == OPC_OP) || (opcode_id == OPC_STORE) ||
                   (opcode_id == OPC_BRANCH);

  assign load_in_ex = valid_ex && (opcode_ex == OPC_LOAD) && (rd_ex != 5'd0);

  assign hz = valid_id && load_in_ex &&
              ((use_rs1 && (rs1_id == rd_ex)) || (use_rs2 && (rs2_id == rd_ex)));

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use stall and branch flush
//
// Optional feature macro: ID_EX_WB_BYPASS_EN (forward the writeback port into
// the captured register read data when the register file is not write-before-read).
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   VALID_ID, PC_ID, IMM_ID, REG_DATA*_ID, FUNCT*_ID, OPCODE_ID, RD/RS*_ID
//                                      decoded instruction from ID
//   PCSrc_EX                           taken branch/jump resolved in EX
//   RegWrite_WB, RD_WB, ALU_DATA_WB    writeback port (bypass only)
//   VALID_EX, *_EX                     registered instruction for EX
//   PCWrite, IF_IDWrite                PC / IF/ID load enables
//   FLUSH_IF_ID                        invalidate IF/ID
//   STALL_COUNT, FLUSH_COUNT           wrapping performance counters
module id_ex_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            VALID_ID,
  input  logic [XLEN-1:0] PC_ID,
  input  logic [XLEN-1:0] IMM_ID,
  input  logic [XLEN-1:0] REG_DATA1_ID,
  input  logic [XLEN-1:0] REG_DATA2_ID,
  input  logic [2:0]      FUNCT3_ID,
  input  logic [6:0]      FUNCT7_ID,
  input  logic [6:0]      OPCODE_ID,
  input  logic [4:0]      RD_ID,
  input  logic [4:0]      RS1_ID,
  input  logic [4:0]      RS2_ID,
  input  logic            PCSrc_EX,
  input  logic            RegWrite_WB,
  input  logic [4:0]      RD_WB,
  input  logic [XLEN-1:0] ALU_DATA_WB,
  output logic            VALID_EX,
  output logic [XLEN-1:0] PC_EX,
  output logic [XLEN-1:0] IMM_EX,
  output logic [XLEN-1:0] REG_DATA1_EX,
  output logic [XLEN-1:0] REG_DATA2_EX,
  output logic [2:0]      FUNCT3_EX,
  output logic [6:0]      FUNCT7_EX,
  output logic [6:0]      OPCODE_EX,
  output logic [4:0]      RD_EX,
  output logic [4:0]      RS1_EX,
  output logic [4:0]      RS2_EX,
  output logic            PCWrite,
  output logic            IF_IDWrite,
  output logic            FLUSH_IF_ID,
  output logic [31:0]     STALL_COUNT,
  output logic [31:0]     FLUSH_COUNT
);

  ex_ctrl_t        ctrl_q;
  ex_ctrl_t        ctrl_id;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rd1_q;
  logic [XLEN-1:0] rd2_q;
  logic [XLEN-1:0] rd1_next;
  logic [XLEN-1:0] rd2_next;
  logic [XLEN-1:0] bubble_data;
  logic            hz;

  assign bubble_data = XLEN'(BUBBLE_DATA);

  hazard_detect u_hazard_detect (
    .opcode_id (OPCODE_ID),
    .rs1_id    (RS1_ID),
    .rs2_id    (RS2_ID),
    .valid_id  (VALID_ID),
    .valid_ex  (ctrl_q.valid),
    .opcode_ex (ctrl_q.opcode),
    .rd_ex     (ctrl_q.rd),
    .hz        (hz)
  );

  always_comb begin
    ctrl_id        = BUBBLE_CTRL;
    ctrl_id.valid  = VALID_ID;
    ctrl_id.funct3 = FUNCT3_ID;
    ctrl_id.funct7 = FUNCT7_ID;
    ctrl_id.opcode = OPCODE_ID;
    ctrl_id.rd     = RD_ID;
    ctrl_id.rs1    = RS1_ID;
    ctrl_id.rs2    = RS2_ID;
  end

`ifdef ID_EX_WB_BYPASS_EN
  // Same-cycle writeback to a source register wins over the stale file read.
  always_comb begin
    rd1_next = REG_DATA1_ID;
    rd2_next = REG_DATA2_ID;
    if (RegWrite_WB && (RD_WB != 5'd0) && (RD_WB == RS1_ID)) begin
      rd1_next = ALU_DATA_WB;
    end
    if (RegWrite_WB && (RD_WB != 5'd0) && (RD_WB == RS2_ID)) begin
      rd2_next = ALU_DATA_WB;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{RegWrite_WB, RD_WB, ALU_DATA_WB};
  assign rd1_next  = REG_DATA1_ID;
  assign rd2_next  = REG_DATA2_ID;
`endif

  // Flush outranks stall: the stalled ID instruction is on the wrong path anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= BUBBLE_CTRL;
      pc_q        <= bubble_data;
      imm_q       <= bubble_data;
      rd1_q       <= bubble_data;
      rd2_q       <= bubble_data;
      STALL_COUNT <= 32'd0;
      FLUSH_COUNT <= 32'd0;
    end else if (PCSrc_EX) begin
      ctrl_q      <= BUBBLE_CTRL;
      pc_q        <= bubble_data;
      imm_q       <= bubble_data;
      rd1_q       <= bubble_data;
      rd2_q       <= bubble_data;
      FLUSH_COUNT <= FLUSH_COUNT + 32'd1;
    end else if (hz) begin
      ctrl_q      <= BUBBLE_CTRL;
      pc_q        <= bubble_data;
      imm_q       <= bubble_data;
      rd1_q       <= bubble_data;
      rd2_q       <= bubble_data;
      STALL_COUNT <= STALL_COUNT + 32'd1;
    end else begin
      ctrl_q      <= ctrl_id;
      pc_q        <= PC_ID;
      imm_q       <= IMM_ID;
      rd1_q       <= rd1_next;
      rd2_q       <= rd2_next;
    end
  end

  assign VALID_EX     = ctrl_q.valid;
  assign FUNCT3_EX    = ctrl_q.funct3;
  assign FUNCT7_EX    = ctrl_q.funct7;
  assign OPCODE_EX    = ctrl_q.opcode;
  assign RD_EX        = ctrl_q.rd;
  assign RS1_EX       = ctrl_q.rs1;
  assign RS2_EX       = ctrl_q.rs2;
  assign PC_EX        = pc_q;
  assign IMM_EX       = imm_q;
  assign REG_DATA1_EX = rd1_q;
  assign REG_DATA2_EX = rd2_q;

  assign PCWrite     = !hz || PCSrc_EX;
  assign IF_IDWrite  = !hz || PCSrc_EX;
  assign FLUSH_IF_ID = PCSrc_EX;

endmodule
